// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the fetch stage (IF) and the memory
// stage (MEM). One transaction at a time is sequenced on the shared port as
// IDLE -> ISSUE -> (WAIT) -> DONE. The read data goes back to whichever
// requester owns the transaction, as a one-cycle valid pulse. MEM normally
// has priority, but a streak counter hands the port to IF after
// P_DM_STREAK_MAX MEM grants in a row while IF is waiting.
module mem_port_arbiter #(
    parameter int P_DATA_WIDTH    = 32,
    parameter int P_ADDR_WIDTH    = 10,
    parameter int P_DM_STREAK_MAX = 4
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    // fetch port
    input  logic                      i_if_req,
    input  logic [P_ADDR_WIDTH-1:0]   i_if_addr,
    input  logic                      i_if_flush,
    output logic [P_DATA_WIDTH-1:0]   o_if_rdata,
    output logic                      o_if_valid,
    // memory-stage port
    input  logic                      i_dm_req,
    input  logic                      i_dm_we,
    input  logic [P_DATA_WIDTH/8-1:0] i_dm_be,
    input  logic [P_ADDR_WIDTH-1:0]   i_dm_addr,
    input  logic [P_DATA_WIDTH-1:0]   i_dm_wdata,
    output logic [P_DATA_WIDTH-1:0]   o_dm_rdata,
    output logic                      o_dm_valid,
    // shared memory port
    output logic                      o_mem_req,
    output logic                      o_mem_we,
    output logic [P_DATA_WIDTH/8-1:0] o_mem_be,
    output logic [P_ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [P_DATA_WIDTH-1:0]   o_mem_wdata,
    input  logic                      i_mem_gnt,
    input  logic                      i_mem_rvalid,
    input  logic [P_DATA_WIDTH-1:0]   i_mem_rdata,
    // hazard-unit holds
    output logic                      o_stall_f,
    output logic                      o_stall_m
);

    localparam int LP_BE_W = P_DATA_WIDTH / 8;
    localparam int LP_SW   = $clog2(P_DM_STREAK_MAX + 1);
    localparam logic [LP_SW-1:0] LP_STREAK_MAX = LP_SW'(P_DM_STREAK_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DM = 1'b1
    } owner_t;

    state_t                    r_state;
    owner_t                    r_owner;
    logic                      r_killed;
    logic [LP_SW-1:0]          r_dm_streak;
    logic                      r_mem_req;
    logic                      r_mem_we;
    logic [LP_BE_W-1:0]        r_mem_be;
    logic [P_ADDR_WIDTH-1:0]   r_mem_addr;
    logic [P_DATA_WIDTH-1:0]   r_mem_wdata;
    logic                      r_if_valid;
    logic                      r_dm_valid;
    logic [P_DATA_WIDTH-1:0]   r_if_rdata;
    logic [P_DATA_WIDTH-1:0]   r_dm_rdata;

    logic w_if_cand;
    logic w_any_req;
    logic w_streak_full;
    logic w_grant_if;
    logic w_in_flight;
    logic w_capture;
    logic w_kill;

    // A flushed fetch takes no part in arbitration that cycle.
    assign w_if_cand     = i_if_req & ~i_if_flush;
    assign w_any_req     = w_if_cand | i_dm_req;
    assign w_streak_full = (r_dm_streak == LP_STREAK_MAX);
    assign w_grant_if    = w_if_cand & (~i_dm_req | w_streak_full);
    assign w_in_flight   = (r_state == S_ISSUE) | (r_state == S_WAIT);
    // rvalid only counts once the request has been accepted (same cycle or earlier).
    assign w_capture     = ((r_state == S_ISSUE) & i_mem_gnt & i_mem_rvalid) |
                           ((r_state == S_WAIT) & i_mem_rvalid);
    assign w_kill        = w_in_flight & (r_owner == OWN_IF) & i_if_flush;

    // Transaction FSM with registered port payload, valid pulses and return data.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_owner     <= OWN_IF;
            r_killed    <= 1'b0;
            r_dm_streak <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_valid  <= 1'b0;
            r_dm_valid  <= 1'b0;
            r_if_rdata  <= '0;
            r_dm_rdata  <= '0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state   <= S_ISSUE;
                        r_mem_req <= 1'b1;
                        r_killed  <= 1'b0;
                        if (w_grant_if) begin
                            r_owner     <= OWN_IF;
                            r_mem_we    <= 1'b0;
                            r_mem_be    <= '1;
                            r_mem_addr  <= i_if_addr;
                            r_mem_wdata <= '0;
                            r_dm_streak <= '0;
                        end else begin
                            r_owner     <= OWN_DM;
                            r_mem_we    <= i_dm_we;
                            r_mem_be    <= i_dm_be;
                            r_mem_addr  <= i_dm_addr;
                            r_mem_wdata <= i_dm_wdata;
                            // Count MEM wins only while IF is actually waiting.
                            if (!i_if_req) begin
                                r_dm_streak <= '0;
                            end else if (!w_streak_full) begin
                                r_dm_streak <= r_dm_streak + LP_SW'(1);
                            end
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_kill) begin
                        r_killed <= 1'b1;
                    end
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_state   <= i_mem_rvalid ? S_DONE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_kill) begin
                        r_killed <= 1'b1;
                    end
                    if (i_mem_rvalid) begin
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // A flushed fetch still completes on the bus but never reaches IF.
            if (w_capture) begin
                if (r_owner == OWN_DM) begin
                    r_dm_valid <= 1'b1;
                    r_dm_rdata <= r_mem_we ? '0 : i_mem_rdata;
                end else if (!r_killed && !i_if_flush) begin
                    r_if_valid <= 1'b1;
                    r_if_rdata <= i_mem_rdata;
                end
            end
        end
    end

    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_be    = r_mem_be;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_if_valid  = r_if_valid;
    assign o_dm_valid  = r_dm_valid;
    assign o_if_rdata  = r_if_rdata;
    assign o_dm_rdata  = r_dm_rdata;

    // Holds drop in the same cycle the completion pulse rises; forced low in reset.
    assign o_stall_f = i_rst_n & i_if_req & ~r_if_valid & ~i_if_flush;
    assign o_stall_m = i_rst_n & i_dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal expectations,
// a transaction-level reference model checked every cycle, and a memory
// responder with configurable grant / completion delays.
module tb_mem_port_arbiter;

    localparam int SMAX = 2;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_if_req;
    logic [9:0]  i_if_addr;
    logic        i_if_flush;
    logic [31:0] o_if_rdata;
    logic        o_if_valid;
    logic        i_dm_req;
    logic        i_dm_we;
    logic [3:0]  i_dm_be;
    logic [9:0]  i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic [31:0] o_dm_rdata;
    logic        o_dm_valid;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [3:0]  o_mem_be;
    logic [9:0]  o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_gnt;
    logic        i_mem_rvalid;
    logic [31:0] i_mem_rdata;
    logic        o_stall_f;
    logic        o_stall_m;

    int n_checks = 0;
    int n_errors = 0;

    mem_port_arbiter #(
        .P_DATA_WIDTH   (32),
        .P_ADDR_WIDTH   (10),
        .P_DM_STREAK_MAX(SMAX)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_if_req    (i_if_req),
        .i_if_addr   (i_if_addr),
        .i_if_flush  (i_if_flush),
        .o_if_rdata  (o_if_rdata),
        .o_if_valid  (o_if_valid),
        .i_dm_req    (i_dm_req),
        .i_dm_we     (i_dm_we),
        .i_dm_be     (i_dm_be),
        .i_dm_addr   (i_dm_addr),
        .i_dm_wdata  (i_dm_wdata),
        .o_dm_rdata  (o_dm_rdata),
        .o_dm_valid  (o_dm_valid),
        .o_mem_req   (o_mem_req),
        .o_mem_we    (o_mem_we),
        .o_mem_be    (o_mem_be),
        .o_mem_addr  (o_mem_addr),
        .o_mem_wdata (o_mem_wdata),
        .i_mem_gnt   (i_mem_gnt),
        .i_mem_rvalid(i_mem_rvalid),
        .i_mem_rdata (i_mem_rdata),
        .o_stall_f   (o_stall_f),
        .o_stall_m   (o_stall_m)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem_arr [0:255];
    bit          resp_auto = 1'b1;
    int          gnt_delay = 0;
    int          rv_delay  = 0;
    bit          man_gnt   = 1'b0;
    bit          man_rv    = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic [9:0]  l_addr;
    logic        l_we;
    logic [3:0]  l_be;
    logic [31:0] l_wdata;

    task automatic complete_txn();
        logic [31:0] w;
        i_mem_rvalid = 1'b1;
        if (l_we) begin
            w = mem_arr[l_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (l_be[b]) w[b*8 +: 8] = l_wdata[b*8 +: 8];
            mem_arr[l_addr[9:2]] = w;
            i_mem_rdata = 32'hDEAD_BEEF;
        end else begin
            i_mem_rdata = mem_arr[l_addr[9:2]];
        end
    endtask

    initial begin
        int cnt;
        int pend;
        cnt = 0;
        pend = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'hC0DE_0000 | i;
        mem_arr[1] = 32'h0050_0113;
        mem_arr[2] = 32'h00A0_0193;
        mem_arr[3] = 32'h1111_1111;
        mem_arr[4] = 32'h0020_8233;
        i_mem_gnt = 1'b0;
        i_mem_rvalid = 1'b0;
        i_mem_rdata = 32'h0;
        forever begin
            @(posedge i_clk);
            #2;
            i_mem_rdata = $urandom;
            if (!resp_auto) begin
                cnt = 0;
                pend = 0;
                i_mem_gnt = man_gnt;
                i_mem_rvalid = man_rv;
                if (man_rv) i_mem_rdata = man_rdata;
            end else if (!i_rst_n) begin
                cnt = 0;
                pend = 0;
                i_mem_gnt = 1'($urandom);
                i_mem_rvalid = 1'($urandom);
            end else begin
                i_mem_gnt = 1'b0;
                i_mem_rvalid = 1'b0;
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) complete_txn();
                end else if (o_mem_req) begin
                    if (cnt >= gnt_delay) begin
                        i_mem_gnt = 1'b1;
                        cnt = 0;
                        l_addr = o_mem_addr;
                        l_we = o_mem_we;
                        l_be = o_mem_be;
                        l_wdata = o_mem_wdata;
                        if (rv_delay == 0) complete_txn();
                        else pend = rv_delay;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction-level view: one job is in flight at a time; it becomes
    // accepted on its first gnt, completes on the first rvalid at or after
    // acceptance, reports in the following cycle, and the port is free again
    // the cycle after that.
    bit          m_busy, m_acc, m_cmpl, m_own_if, m_killed, m_fire_if, m_fire_dm;
    int          m_streak;
    logic [9:0]  m_addr;
    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata, m_if_rd, m_dm_rd;
    bit          prev_req;
    logic [9:0]  glog[$];

    task automatic model_reset();
        m_busy = 0; m_acc = 0; m_cmpl = 0; m_own_if = 0; m_killed = 0;
        m_fire_if = 0; m_fire_dm = 0; m_streak = 0;
        m_addr = '0; m_we = 1'b0; m_be = '0; m_wdata = '0;
        prev_req = 0;
    endtask

    initial begin
        bit e_req, e_ifv, e_dmv, ifc;
        model_reset();
        forever begin
            @(negedge i_clk);
            if (!i_rst_n) begin
                chk("rst_mem_req", 32'(o_mem_req), 0);
                chk("rst_mem_we", 32'(o_mem_we), 0);
                chk("rst_mem_be", 32'(o_mem_be), 0);
                chk("rst_mem_addr", 32'(o_mem_addr), 0);
                chk("rst_mem_wdata", o_mem_wdata, 0);
                chk("rst_if_valid", 32'(o_if_valid), 0);
                chk("rst_dm_valid", 32'(o_dm_valid), 0);
                chk("rst_if_rdata", o_if_rdata, 0);
                chk("rst_dm_rdata", o_dm_rdata, 0);
                chk("rst_stall_f", 32'(o_stall_f), 0);
                chk("rst_stall_m", 32'(o_stall_m), 0);
                model_reset();
            end else begin
                e_req = m_busy && !m_acc;
                e_ifv = m_busy && m_cmpl && m_fire_if;
                e_dmv = m_busy && m_cmpl && m_fire_dm;
                chk("m_mem_req", 32'(o_mem_req), 32'(e_req));
                chk("m_mem_addr", 32'(o_mem_addr), 32'(m_addr));
                chk("m_mem_we", 32'(o_mem_we), 32'(m_we));
                chk("m_mem_be", 32'(o_mem_be), 32'(m_be));
                chk("m_mem_wdata", o_mem_wdata, m_wdata);
                chk("m_if_valid", 32'(o_if_valid), 32'(e_ifv));
                chk("m_dm_valid", 32'(o_dm_valid), 32'(e_dmv));
                if (e_ifv) chk("m_if_rdata", o_if_rdata, m_if_rd);
                if (e_dmv) chk("m_dm_rdata", o_dm_rdata, m_dm_rd);
                chk("m_stall_f", 32'(o_stall_f), 32'(i_if_req && !e_ifv && !i_if_flush));
                chk("m_stall_m", 32'(o_stall_m), 32'(i_dm_req && !e_dmv));
                if (o_mem_req && !prev_req) glog.push_back(o_mem_addr);
                prev_req = o_mem_req;

                if (m_busy) begin
                    if (m_cmpl) begin
                        m_busy = 0;
                    end else begin
                        if (m_own_if && i_if_flush) m_killed = 1;
                        if (!m_acc && i_mem_gnt) m_acc = 1;
                        if (m_acc && i_mem_rvalid) begin
                            m_cmpl = 1;
                            if (m_own_if) begin
                                m_fire_if = !m_killed;
                                m_if_rd = i_mem_rdata;
                            end else begin
                                m_fire_dm = 1;
                                m_dm_rd = m_we ? 32'h0 : i_mem_rdata;
                            end
                        end
                    end
                end else begin
                    ifc = i_if_req && !i_if_flush;
                    if (ifc || i_dm_req) begin
                        m_busy = 1; m_acc = 0; m_cmpl = 0; m_killed = 0;
                        m_fire_if = 0; m_fire_dm = 0;
                        if (ifc && (!i_dm_req || m_streak == SMAX)) begin
                            m_own_if = 1;
                            m_addr = i_if_addr; m_we = 1'b0; m_be = 4'hF; m_wdata = 32'h0;
                            m_streak = 0;
                        end else begin
                            m_own_if = 0;
                            m_addr = i_dm_addr; m_we = i_dm_we; m_be = i_dm_be; m_wdata = i_dm_wdata;
                            if (!i_if_req) m_streak = 0;
                            else if (m_streak < SMAX) m_streak++;
                        end
                    end
                end
            end
        end
    end

    task automatic wait_valid(input bit is_if, input int bound, output int lat);
        lat = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (is_if ? o_if_valid : o_dm_valid) begin
                lat = k;
                break;
            end
        end
        if (lat < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_valid_timeout: got no valid within %0d cycles expected a pulse", bound);
        end
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int lat;
        int vcnt;
        logic [9:0] exp_order [4];
        i_rst_n = 1'b0;
        i_if_req = 1'b0; i_if_addr = '0; i_if_flush = 1'b0;
        i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_be = '0; i_dm_addr = '0; i_dm_wdata = '0;

        // Reset with random inputs
        repeat (5) begin
            tick();
            i_if_req = 1'($urandom); i_if_addr = 10'($urandom); i_if_flush = 1'($urandom);
            i_dm_req = 1'b1; i_dm_we = 1'($urandom); i_dm_be = 4'($urandom);
            i_dm_addr = 10'($urandom); i_dm_wdata = $urandom;
        end
        #1;
        chk("reset_stall_m", 32'(o_stall_m), 0);
        chk("reset_mem_req", 32'(o_mem_req), 0);
        tick();
        i_if_req = 1'b0; i_if_flush = 1'b0; i_dm_req = 1'b0; i_dm_we = 1'b0;
        i_rst_n = 1'b1;
        tick();
        chk("post_reset_idle_req", 32'(o_mem_req), 0);

        // Single fetch, zero-wait memory
        i_if_req = 1'b1; i_if_addr = 10'h004;
        #1 chk("fetch_stall_c0", 32'(o_stall_f), 1);
        tick();
        chk("fetch_issue_req", 32'(o_mem_req), 1);
        chk("fetch_issue_addr", 32'(o_mem_addr), 32'h004);
        chk("fetch_stall_c1", 32'(o_stall_f), 1);
        chk("fetch_valid_c1", 32'(o_if_valid), 0);
        tick();
        chk("fetch_valid_c2", 32'(o_if_valid), 1);
        chk("fetch_rdata", o_if_rdata, 32'h0050_0113);
        chk("fetch_stall_c2", 32'(o_stall_f), 0);
        tick();
        i_if_req = 1'b0;
        chk("fetch_valid_c3", 32'(o_if_valid), 0);
        tick();

        // Contention: MEM write beats IF read
        i_if_req = 1'b1; i_if_addr = 10'h008;
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 10'd100; i_dm_wdata = 32'd25; i_dm_be = 4'hF;
        tick();
        chk("cont_mem_req", 32'(o_mem_req), 1);
        chk("cont_mem_we", 32'(o_mem_we), 1);
        chk("cont_mem_addr", 32'(o_mem_addr), 100);
        chk("cont_mem_wdata", o_mem_wdata, 25);
        chk("cont_mem_be", 32'(o_mem_be), 32'hF);
        tick();
        chk("cont_dm_valid", 32'(o_dm_valid), 1);
        chk("cont_dm_rdata_write", o_dm_rdata, 0);
        chk("cont_if_waiting", 32'(o_stall_f), 1);
        tick();
        i_dm_req = 1'b0; i_dm_we = 1'b0;
        chk("cont_idle_req", 32'(o_mem_req), 0);
        tick();
        chk("cont_if_issue_req", 32'(o_mem_req), 1);
        chk("cont_if_issue_addr", 32'(o_mem_addr), 32'h008);
        chk("cont_if_issue_we", 32'(o_mem_we), 0);
        chk("cont_if_issue_be", 32'(o_mem_be), 32'hF);
        tick();
        chk("cont_if_valid", 32'(o_if_valid), 1);
        chk("cont_if_rdata", o_if_rdata, 32'h00A0_0193);
        tick();
        i_if_req = 1'b0;
        tick();

        // Partial byte-enable write, then read back
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 10'd100; i_dm_wdata = 32'hFFFF_FFFF; i_dm_be = 4'b0011;
        tick();
        chk("be_pass_through", 32'(o_mem_be), 32'h3);
        wait_valid(1'b0, 8, lat);
        tick();
        i_dm_we = 1'b0; i_dm_be = 4'hF;
        wait_valid(1'b0, 8, lat);
        chk("be_readback", o_dm_rdata, 32'h0000_FFFF);
        tick();
        i_dm_req = 1'b0;
        tick();

        // Flush while IF owns WAIT
        rv_delay = 3;
        i_if_req = 1'b1; i_if_addr = 10'h00C;
        tick();
        tick();
        chk("flush_wait_req", 32'(o_mem_req), 0);
        i_if_flush = 1'b1;
        #1 chk("flush_stall_f", 32'(o_stall_f), 0);
        vcnt = 0;
        for (int k = 0; k < 7; k++) begin
            tick();
            if (k == 0) begin
                i_if_flush = 1'b0;
                i_if_req = 1'b0;
            end
            if (o_if_valid) vcnt++;
        end
        chk("flush_no_valid", vcnt, 0);
        chk("flush_back_idle", 32'(o_mem_req), 0);
        rv_delay = 1;
        i_if_req = 1'b1; i_if_addr = 10'h010;
        wait_valid(1'b1, 10, lat);
        chk("after_flush_latency", lat, 3);
        chk("after_flush_rdata", o_if_rdata, 32'h0020_8233);
        tick();
        i_if_req = 1'b0;
        rv_delay = 0;
        tick();
        tick();

        // Starvation guard: grant order MEM, MEM, IF, MEM
        glog.delete();
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 10'h040; i_dm_be = 4'hF;
        i_if_req = 1'b1; i_if_addr = 10'h080;
        repeat (14) tick();
        i_dm_req = 1'b0; i_if_req = 1'b0;
        repeat (5) tick();
        exp_order[0] = 10'h040; exp_order[1] = 10'h040; exp_order[2] = 10'h080; exp_order[3] = 10'h040;
        chk("starve_grant_count_ge4", 32'(glog.size() >= 4), 1);
        for (int k = 0; k < 4; k++)
            if (k < glog.size()) chk($sformatf("starve_grant_%0d", k), 32'(glog[k]), 32'(exp_order[k]));

        // Gnt backpressure, then reset during WAIT
        resp_auto = 1'b0; man_gnt = 1'b0; man_rv = 1'b0;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 10'h020; i_dm_be = 4'hF;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("bp_req_%0d", k), 32'(o_mem_req), 1);
            chk($sformatf("bp_addr_%0d", k), 32'(o_mem_addr), 32'h020);
        end
        tick();
        man_gnt = 1'b1;
        chk("bp_req_at_gnt", 32'(o_mem_req), 1);
        tick();
        man_gnt = 1'b0;
        chk("bp_wait_req", 32'(o_mem_req), 0);
        chk("bp_wait_addr", 32'(o_mem_addr), 32'h020);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_mem_addr", 32'(o_mem_addr), 0);
        chk("midrst_mem_be", 32'(o_mem_be), 0);
        chk("midrst_stall_m", 32'(o_stall_m), 0);
        chk("midrst_if_rdata", o_if_rdata, 0);
        i_dm_req = 1'b0;
        tick();
        i_rst_n = 1'b1;
        man_rv = 1'b1; man_rdata = 32'h1234_5678;
        vcnt = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 0) man_rv = 1'b0;
            if (o_dm_valid) vcnt++;
        end
        chk("late_rvalid_ignored", vcnt, 0);
        chk("late_rvalid_rdata", o_dm_rdata, 0);
        resp_auto = 1'b1;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
